// File: rtl/approx_seq_mul_if.sv
// Handshake/data bundle for the approximate sequential multiplier.
// The driving side uses master; the multiplier uses slave.
interface approx_seq_mul_if #(
    parameter int W = 8
);
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] p;

    modport master (output start, a, b, input busy, done, p);
    modport slave  (input start, a, b, output busy, done, p);
endinterface

// File: rtl/approx_seq_mul.sv
// Radix-2 shift-add unsigned multiplier, one multiplier bit per clock.
// The low APPROX_BITS accumulator columns use carry-free OR cells.
module approx_seq_mul #(
    parameter int W           = 8,
    parameter int APPROX_BITS = 0
) (
    input  logic            clk,
    input  logic            rst,
    approx_seq_mul_if.slave bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         r_state;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [2*W-1:0] r_acc;
    logic [2*W-1:0] r_p;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic           r_done;

    logic [2*W-1:0] w_addend;
    logic [2*W-1:0] w_sum;

    assign w_addend = r_b[0] ? ({{W{1'b0}}, r_a} << r_cnt) : '0;

    // Approximate columns generate no carry, so the exact upper add starts with carry-in 0.
    generate
        if (APPROX_BITS == 0) begin : g_exact
            assign w_sum = r_acc + w_addend;
        end else begin : g_approx
            assign w_sum[APPROX_BITS-1:0]     = r_acc[APPROX_BITS-1:0] | w_addend[APPROX_BITS-1:0];
            assign w_sum[2*W-1:APPROX_BITS]   = r_acc[2*W-1:APPROX_BITS] + w_addend[2*W-1:APPROX_BITS];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_p     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_RUN: begin
                    r_acc <= w_sum;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(W - 1)) begin
                        r_p     <= w_sum;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                // IDLE and DONE accept identically, giving back-to-back issue from DONE.
                default: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.p    = r_p;
endmodule

// File: tb/tb_approx_seq_mul.sv
// Bench for approx_seq_mul: an exact instance and an APPROX_BITS=4 instance
// checked against an arithmetic reference of the multiply and approximate add.
module tb_approx_seq_mul;
    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;
    logic [15:0] last_p [2];

    always #5 clk = ~clk;

    approx_seq_mul_if #(.W(8)) bx ();
    approx_seq_mul_if #(.W(8)) bq ();

    approx_seq_mul #(.W(8), .APPROX_BITS(0)) dut_x (.clk(clk), .rst(rst), .bus(bx.slave));
    approx_seq_mul #(.W(8), .APPROX_BITS(4)) dut_q (.clk(clk), .rst(rst), .bus(bq.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic s, input logic [7:0] a, input logic [7:0] b);
        if (sel == 0) begin
            bx.start = s; bx.a = a; bx.b = b;
        end else begin
            bq.start = s; bq.a = a; bq.b = b;
        end
    endtask

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? bx.busy : bq.busy;
    endfunction
    function automatic logic get_done(input int sel);
        return (sel == 0) ? bx.done : bq.done;
    endfunction
    function automatic logic [15:0] get_p(input int sel);
        return (sel == 0) ? bx.p : bq.p;
    endfunction

    // Sum of shifted partial products folded with the approximate adder rule.
    function automatic int approx_ref(input int ab, input int a, input int b);
        int acc = 0;
        int add;
        int lo;
        int hi;
        for (int i = 0; i < 8; i++) begin
            add = (((b >> i) & 1) != 0) ? (a << i) : 0;
            if (ab == 0) begin
                acc = (acc + add) % 65536;
            end else begin
                lo  = (acc | add) % (1 << ab);
                hi  = ((acc >> ab) + (add >> ab)) % (1 << (16 - ab));
                acc = hi * (1 << ab) + lo;
            end
        end
        return acc;
    endfunction

    // Issues one operation and returns at the negedge where done is seen.
    task automatic do_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                         input bit poke, input int exp, input string tag,
                         output logic [15:0] p_o);
        int lat;
        int bcnt;
        @(negedge clk);
        drive(sel, 1'b1, a, b);
        @(negedge clk);
        drive(sel, 1'b0, 8'($urandom), 8'($urandom));
        lat  = 0;
        bcnt = 0;
        while (!get_done(sel) && lat < 40) begin
            if (get_busy(sel)) bcnt++;
            if (lat == 7) chk({tag, "_p_hold"}, 32'(get_p(sel)), 32'(last_p[sel]));
            if (poke && lat == 3) drive(sel, 1'b1, 8'd1, 8'd1);
            if (poke && lat == 4) drive(sel, 1'b0, 8'd0, 8'd0);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_done"}, 32'(get_done(sel)), 32'd1);
        chk({tag, "_lat"}, lat, 8);
        chk({tag, "_busycyc"}, bcnt, 8);
        chk({tag, "_busy_at_done"}, 32'(get_busy(sel)), 32'd0);
        p_o = get_p(sel);
        chk({tag, "_p"}, 32'(p_o), exp);
        last_p[sel] = 16'(exp);
    endtask

    task automatic after_done(input int sel, input string tag);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(get_done(sel)), 32'd0);
        chk({tag, "_busy_idle"}, 32'(get_busy(sel)), 32'd0);
        chk({tag, "_p_held"}, 32'(get_p(sel)), 32'(last_p[sel]));
    endtask

    initial begin
        logic [15:0] pr;
        int n;
        int dones;
        int ai;
        int bi;

        rst = 1'b1;
        drive(0, 1'b0, 8'd0, 8'd0);
        drive(1, 1'b0, 8'd0, 8'd0);
        last_p[0] = '0;
        last_p[1] = '0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_busy", 32'(get_busy(s)), 32'd0);
            chk("rst_done", 32'(get_done(s)), 32'd0);
            chk("rst_p", 32'(get_p(s)), 32'd0);
        end
        rst = 1'b0;

        do_op(0, 8'd255, 8'd255, 1'b0, 65025, "t1", pr);
        after_done(0, "t1");

        do_op(1, 8'd15, 8'd3, 1'b0, 31, "t2", pr);
        after_done(1, "t2");

        do_op(0, 8'd0, 8'd200, 1'b0, 0, "t3a", pr);
        after_done(0, "t3a");
        do_op(0, 8'd37, 8'd1, 1'b0, 37, "t3b", pr);
        after_done(0, "t3b");

        do_op(0, 8'd12, 8'd10, 1'b0, 120, "t4a", pr);
        drive(0, 1'b1, 8'd7, 8'd9);
        @(negedge clk);
        drive(0, 1'b0, 8'd0, 8'd0);
        chk("t4_busy_next", 32'(get_busy(0)), 32'd1);
        chk("t4_done_next", 32'(get_done(0)), 32'd0);
        chk("t4_p_kept", 32'(get_p(0)), 32'd120);
        n = 1;
        while (!get_done(0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t4_gap", n, 9);
        chk("t4_p2", 32'(get_p(0)), 32'd63);
        last_p[0] = 16'd63;
        after_done(0, "t4b");

        do_op(0, 8'd100, 8'd3, 1'b1, 300, "t5", pr);
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (get_done(0)) dones++;
        end
        chk("t5_extra_done", dones, 0);
        chk("t5_p_final", 32'(get_p(0)), 32'd300);

        for (int k = 0; k < 25; k++) begin
            ai = int'($urandom_range(0, 255));
            bi = int'($urandom_range(0, 255));
            do_op(0, 8'(ai), 8'(bi), 1'b0, ai * bi, "rnd_exact", pr);
            do_op(1, 8'(ai), 8'(bi), 1'b0, approx_ref(4, ai, bi), "rnd_approx", pr);
            chk("rnd_approx_le", 32'(int'(pr) <= ai * bi), 32'd1);
        end
        after_done(1, "rnd_tail");

        @(negedge clk);
        drive(0, 1'b1, 8'd200, 8'd200);
        @(negedge clk);
        drive(0, 1'b0, 8'd0, 8'd0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_busy", 32'(get_busy(0)), 32'd0);
        chk("t6_done", 32'(get_done(0)), 32'd0);
        chk("t6_p", 32'(get_p(0)), 32'd0);
        chk("t6_p_q", 32'(get_p(1)), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_p[0] = '0;
        last_p[1] = '0;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (get_done(0)) dones++;
        end
        chk("t6_no_done", dones, 0);
        chk("t6_p_still0", 32'(get_p(0)), 32'd0);
        do_op(0, 8'd3, 8'd5, 1'b0, 15, "t6b", pr);
        after_done(0, "t6b");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/approx_seq_mul.md
Name: approx_seq_mul

Overview:
- Iterative radix-2 shift-add unsigned multiplier: W-bit multiplicand × W-bit multiplier → 2W-bit product, one multiplier bit per clock.
- Inverse-direction companion to the 16/8 approximate restoring array divider in the same approximate-arithmetic library.
- Low-order accumulation columns can be made approximate (carry-free OR), mirroring the divider's approximate LSB subtractor cells.
- Used standalone and as a reconstruction checker: q*y + r against the dividend x.

Parameters:
- W, 8, operand width; product is 2W bits.
- APPROX_BITS, 0, number of low accumulator columns (0..2W-1) built with approximate OR cells; 0 = exact.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only when idle (IDLE or DONE state).
- a  input  W  multiplicand; captured on the accepting edge.
- b  input  W  multiplier; captured on the accepting edge.
- busy  output  1  high while state = RUN.
- done  output  1  single-cycle pulse; p is valid.
- p  output  2W  product; holds its value until the next completion.

Behaviour:
- Reset, asynchronous: state=IDLE, busy=0, done=0, p=0, internal acc/count/operand registers=0. Reset mid-RUN aborts the operation. No done pulse follows; p reads 0.
- FSM states are IDLE, RUN and DONE.
- IDLE: when start=1, the edge latches a_r=a and b_r=b, clears acc=0 and cnt=0, and moves to RUN. Otherwise stay in IDLE.
- RUN: each edge:
  - addend = b_r[0] ? (a_r << cnt) : 0, with a_r zero-extended to 2W bits.
  - acc = approx_add(acc, addend); b_r shifts right 1; cnt increments.
  - On the edge where cnt = W-1 (the W-th RUN edge): p = the new acc result, state moves to DONE.
- DONE: done=1 for exactly this one cycle.
  - If start=1 in this cycle, the operation is accepted as in IDLE and the next state is RUN (back-to-back, no bubble).
  - Otherwise the next state is IDLE.
- Latency: done is high W cycles after the start-accepting edge (8 for W=8). Throughput: one product per W+1 cycles, including back-to-back operation.
- start while busy=1: ignored. Operands are not re-captured and the in-flight result is unaffected.
- approx_add(x,y), 2W bits:
  - Bits [APPROX_BITS-1:0] = x|y, with no carry generated.
  - Bits [2W-1:APPROX_BITS] = x[2W-1:APPROX_BITS] + y[2W-1:APPROX_BITS], with carry-in 0; the carry-out is discarded.
  - APPROX_BITS=0 gives an exact 2W-bit add.
  - Exact mode cannot overflow, since the maximum is (2^W-1)^2.
- Properties:
  - APPROX_BITS=0: p == a*b exactly, for all inputs.
  - APPROX_BITS>0: p <= a*b, and p[2W-1:APPROX_BITS] differs from the exact product only through lost low-column carries.
- Operands a and b may change freely after the accepting edge.
- busy and done are never high simultaneously.

Test Plan:
1. APPROX_BITS=0, a=255, b=255, start pulsed one cycle -> busy high 8 cycles; done pulse 8 cycles after the accepting edge; p=65025 (0xFE01), held afterwards.
2. APPROX_BITS=4, a=15, b=3 -> p=31 (0x001F); exact product is 45; confirms OR columns and no carry into bit 4.
3. APPROX_BITS=0, a=0, b=200, then a=37, b=1 -> p=0, then p=37; p keeps 0 between the two operations until the second done.
4. Back-to-back: a=12, b=10, with start=1 again during the DONE cycle carrying a=7, b=9 -> first done p=120; busy rises the next cycle; second done exactly 9 cycles after the first, p=63.
5. start re-asserted with a=1, b=1 mid-RUN of a=100, b=3 -> ignored; p=300; only one done pulse.
6. rst asserted asynchronously (between edges) at RUN cycle 4 of a=200, b=200 -> busy, done and p drop to 0 immediately; no done follows. A new start after rst release with a=3, b=5 -> p=15.
